// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared constants and types for the line memory responder
//
// Package mem_pkg: line/address geometry, FSM state type and the line-index
// width helper used by the interface, top module and latency counter.
// No ports.
package mem_pkg;

  localparam int LINE_W   = 256;  // one cache line, 32 bytes
  localparam int ADDR_W   = 32;   // byte address width
  localparam int OFFSET_W = 5;    // byte offset within a line

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Number of address bits needed to index DEPTH lines (never narrower than 1).
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - cache-line memory request/response bus
//
// Interface line_mem_if groups the request and response signals.
//   master modport (cache side):  drives addr_i, data_i, enable_i, write_i;
//                                 observes ack_o, data_o (and err_o)
//   slave modport (memory side):  the mirror image
// Optional: MEM_RANGE_CHECK_EN adds err_o (out-of-range completion flag).
interface line_mem_if #(
  parameter int LINE_W = mem_pkg::LINE_W
);

  logic [mem_pkg::ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0]          data_i;
  logic                       enable_i;
  logic                       write_i;
  logic                       ack_o;
  logic [LINE_W-1:0]          data_o;
`ifdef MEM_RANGE_CHECK_EN
  logic                       err_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, err_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, err_o
  );
`else
  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );
`endif

endinterface

// File: rtl/line_mem_responder_latency_ctr.sv
// rtl/line_mem_responder_latency_ctr.sv - access latency counter with terminal count
//
// Module mem_latency_ctr: clear/enable up-counter of width clog2(LATENCY)+1.
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (count -> 0)
//   clear_i  in   synchronous clear (priority over en_i)
//   en_i     in   increment enable
//   tc_o     out  high while the next increment reaches LATENCY, i.e. the
//                 coming edge is the LATENCY-th since the count was cleared
module mem_latency_ctr #(
  parameter int LATENCY = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (en_i) begin
      count <= count + 1'b1;
    end
  end

  // The owning FSM leaves the counting state on the edge where count reaches
  // LATENCY, so the counter never wraps inside a request.
  assign tc_o = (count == CNT_W'(LATENCY - 1));

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - memory-side responder for 256-bit cache-line requests
//
// Accepts one line read or write at a time, waits LATENCY edges, performs the
// access and pulses ack_o for one cycle.
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous active-high reset (memory array is not cleared)
//   bus     slave modport of line_mem_if:
//             addr_i   byte address, line index = addr_i[OFFSET_W +: IDX_W]
//             data_i   write line
//             enable_i request valid, held until ack_o
//             write_i  1 = write, 0 = read
//             ack_o    one-cycle completion pulse
//             data_o   read line, held until the next read completes
//             err_o    (MEM_RANGE_CHECK_EN only) out-of-range flag, pulses with ack_o
// Optional: MEM_RANGE_CHECK_EN rejects addresses with non-zero bits above the
// line index; without it those bits are ignored and addresses alias.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int LINE_W  = mem_pkg::LINE_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  line_mem_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int HI_LO = OFFSET_W + IDX_W;  // first address bit above the index

  logic [LINE_W-1:0] mem [DEPTH];

  mem_state_t        state;
  logic [IDX_W-1:0]  req_line;
  logic              req_write;
  logic [LINE_W-1:0] req_data;
  logic              req_oor;
  logic              ack_q;
  logic              err_q;
  logic [LINE_W-1:0] data_q;

  logic [IDX_W-1:0]  addr_line;
  logic              addr_oor;
  logic              tc;
  logic              access;
  logic              mem_we;
  logic              unused_addr_bits;

  assign addr_line = bus.addr_i[OFFSET_W +: IDX_W];

`ifdef MEM_RANGE_CHECK_EN
  assign addr_oor         = |bus.addr_i[ADDR_W-1:HI_LO];
  assign unused_addr_bits = ^bus.addr_i[OFFSET_W-1:0];
`else
  // Upper bits are deliberately dropped: lines alias modulo DEPTH.
  assign addr_oor         = 1'b0;
  assign unused_addr_bits = ^{bus.addr_i[ADDR_W-1:HI_LO], bus.addr_i[OFFSET_W-1:0]};
`endif

  mem_latency_ctr #(
    .LATENCY (LATENCY)
  ) u_latency_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state == IDLE),
    .en_i    (state == BUSY),
    .tc_o    (tc)
  );

  // The access happens on the LATENCY-th edge after accept.
  assign access = (state == BUSY) && tc;
  assign mem_we = access && req_write && !req_oor;

  // The array has no reset; an aborted request never reaches mem_we because
  // reset forces the FSM to IDLE before the completing edge.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[req_line] <= req_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      req_line  <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
      req_oor   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.enable_i) begin
            req_line  <= addr_line;
            req_write <= bus.write_i;
            req_data  <= bus.data_i;
            req_oor   <= addr_oor;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Request inputs are not looked at here: the captured copy completes.
          if (access) begin
            if (!req_write) begin
              data_q <= req_oor ? '0 : mem[req_line];
            end
            ack_q <= 1'b1;
            err_q <= req_oor;
            state <= DONE;
          end
        end
        DONE: begin
          // enable_i is ignored for this cycle, so the earliest re-accept is
          // two edges after the completing one.
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.err_o  = err_q;
`endif

endmodule
